// File: rtl/vram_dbuf_loader_if.sv
// Pixel write stream, display read port and frame status of the double-buffered VRAM.
// master = upstream pixel source / display timing, slave = vram_dbuf_loader.
interface vram_dbuf_loader_if #(
    parameter int ADDR_W = 14
);
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_sof;
    logic [2:0]        wr_pixel;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              vsync;
    logic [2:0]        rd_rgb;
    logic              frame_ready;
    logic              sof_err;
    logic              front_sel;

    modport master (
        output wr_valid, wr_sof, wr_pixel, rd_en, rd_addr, vsync,
        input  wr_ready, rd_rgb, frame_ready, sof_err, front_sel
    );

    modport slave (
        input  wr_valid, wr_sof, wr_pixel, rd_en, rd_addr, vsync,
        output wr_ready, rd_rgb, frame_ready, sof_err, front_sel
    );
endinterface

// File: rtl/vram_dbuf_loader.sv
// Double-buffered 3-bpp frame buffer: stream fills back bank, banks swap on vsync fall.
// Read latency 1 cycle; wr_ready drops while a full frame waits for the swap (and during CLEAR).
// Optional VRAM_CLEAR_EN: zero both banks after reset before accepting pixels.
module vram_dbuf_loader #(
    parameter int H_RES  = 128,
    parameter int V_RES  = 96,
    parameter int ADDR_W = 14
) (
    input logic                clk,
    input logic                reset,
    vram_dbuf_loader_if.slave  bus
);
    localparam int                DEPTH     = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FILL, S_WAIT} state_t;

`ifdef VRAM_CLEAR_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    logic [2:0] bank0 [DEPTH];
    logic [2:0] bank1 [DEPTH];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic              front_sel, front_sel_nxt;
    logic              vsync_q;
    logic              err_nxt;
    logic              mem_we, clr_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_dat;
    logic              accept, vsync_fall;

    assign bus.wr_ready    = (state == S_IDLE) || (state == S_FILL);
    assign bus.frame_ready = (state == S_WAIT);
    assign bus.front_sel   = front_sel;
    assign accept          = bus.wr_valid && bus.wr_ready;
    assign vsync_fall      = vsync_q && !bus.vsync;

    always_comb begin
        state_nxt     = state;
        wr_addr_nxt   = wr_addr;
        front_sel_nxt = front_sel;
        err_nxt       = 1'b0;
        mem_we        = 1'b0;
        clr_we        = 1'b0;
        mem_addr      = wr_addr;
        mem_dat       = bus.wr_pixel;
        case (state)
            S_CLEAR: begin
                clr_we  = 1'b1;
                mem_dat = 3'b000;
                if (wr_addr == LAST_ADDR) begin
                    wr_addr_nxt = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    wr_addr_nxt = wr_addr + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (bus.wr_sof) begin
                        mem_we      = 1'b1;
                        mem_addr    = '0;
                        wr_addr_nxt = ADDR_W'(1);
                        state_nxt   = S_FILL;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    mem_we = 1'b1;
                    // A new start-of-frame restarts the fill from address 0.
                    if (bus.wr_sof) begin
                        mem_addr    = '0;
                        wr_addr_nxt = ADDR_W'(1);
                        err_nxt     = 1'b1;
                    end else if (wr_addr == LAST_ADDR) begin
                        wr_addr_nxt = '0;
                        state_nxt   = S_WAIT;
                    end else begin
                        wr_addr_nxt = wr_addr + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (vsync_fall) begin
                    front_sel_nxt = !front_sel;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RST_STATE;
            wr_addr     <= '0;
            front_sel   <= 1'b0;
            vsync_q     <= 1'b1;
            bus.sof_err <= 1'b0;
            bus.rd_rgb  <= 3'b000;
        end else begin
            state       <= state_nxt;
            wr_addr     <= wr_addr_nxt;
            front_sel   <= front_sel_nxt;
            vsync_q     <= bus.vsync;
            bus.sof_err <= err_nxt;
            if (state != S_CLEAR && bus.rd_en && bus.rd_addr <= LAST_ADDR)
                bus.rd_rgb <= front_sel ? bank1[bus.rd_addr] : bank0[bus.rd_addr];
            else
                bus.rd_rgb <= 3'b000;
        end
    end

    // Back bank is ~front_sel, so a pixel write targets bank0 only while bank1 is shown.
    always_ff @(posedge clk) begin
        if (clr_we || (mem_we && front_sel))
            bank0[mem_addr] <= mem_dat;
        if (clr_we || (mem_we && !front_sel))
            bank1[mem_addr] <= mem_dat;
    end
endmodule

// File: doc/vram_dbuf_loader.md
Name: vram_dbuf_loader

Overview:
- Double-buffered 128x96, 3-bit-per-pixel (R,G,B) video frame buffer with a streaming pixel write port.
- Replaces the single-bank vram stage. The display side reads the front bank with the 14-bit address produced by the address-control logic; the upstream pixel source fills the back bank.
- Banks swap only at the start of the vertical sync pulse, so a frame never tears.

Parameters:
- H_RES, 128, pixels per line.
- V_RES, 96, lines per frame.
- ADDR_W, 14, address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write pixel valid.
- wr_ready  output  1  write pixel accepted when wr_valid & wr_ready.
- wr_sof  input  1  qualifies the first pixel of a frame; sampled with wr_valid.
- wr_pixel  input  3  {R,G,B} pixel value.
- rd_en  input  1  display active (H pixel display AND V pixel display).
- rd_addr  input  ADDR_W  display read address, raster order.
- vsync  input  1  VGA vertical sync, active low.
- rd_rgb  output  3  {R,G,B} to the VGA pins, registered.
- frame_ready  output  1  back bank full and waiting for a swap.
- sof_err  output  1  one-cycle pulse on a restart or a dropped pixel.
- front_sel  output  1  bank currently displayed.

Behaviour:
- Reset (reset=0, async): state=IDLE, wr_addr=0, front_sel=0, rd_rgb=0, frame_ready=0, sof_err=0, vsync_q=1. Memory contents are not cleared unless the optional feature is enabled.
- Write FSM states:
  - IDLE: wr_ready=1.
    - Accept with wr_sof=1: write to back[0], wr_addr=1, go to FILL.
    - Accept with wr_sof=0: pixel is discarded and sof_err pulses.
  - FILL: wr_ready=1.
    - Each accept writes back[wr_addr] and increments wr_addr.
    - Accept with wr_sof=1: write back[0], wr_addr=1, sof_err pulses, stay in FILL (frame restart).
    - Accept at wr_addr = H_RES*V_RES-1 (12287): write, wr_addr=0, go to WAIT_SWAP.
  - WAIT_SWAP: wr_ready=0, frame_ready=1.
    - On a vsync falling edge (vsync_q=1, vsync=0): toggle front_sel, frame_ready=0, go to IDLE.
- Back bank is always ~front_sel. Writes never touch the front bank.
- A vsync falling edge in IDLE or FILL has no effect. No swap happens without a complete frame.
- Swap and the last write in the same cycle: the last write completes first; the swap needs a later vsync edge.
- Read path:
  - Latency 1 cycle: rd_rgb(t+1) = front[rd_addr(t)] when rd_en(t)=1 and rd_addr(t) < 12288; otherwise 0.
  - The bank used for a read is front_sel sampled in the same cycle as rd_addr.
- vsync_q is a registered copy of vsync used for edge detection.
- Reset mid-FILL aborts the frame. The next frame must begin with wr_sof.

Optional Feature:
- Macro: VRAM_CLEAR_EN.
- Defined:
  - After reset deassert, a CLEAR state writes 0 to both banks at one address per cycle, 12288 cycles, then enters IDLE.
  - During CLEAR: wr_ready=0, rd_rgb=0.
  - Reassertion of reset during CLEAR restarts the clear.
- Undefined:
  - No CLEAR state; IDLE is entered immediately after reset.
  - Memory holds initial or undefined contents until it is written.

Test Plan:
- Reset, then stream 12288 pixels with wr_sof on the first, value = addr[2:0] -> frame_ready=1 and wr_ready=0 after the last accept; front_sel stays 0 until the next vsync 1->0, then front_sel=1 and frame_ready=0.
- After the swap, read with rd_en=1, rd_addr=5 -> rd_rgb=3'b101 one cycle later. With rd_en=0 -> rd_rgb=0. With rd_addr=12300 -> rd_rgb=0.
- Send 100 pixels, then wr_sof=1 with pixel 3'b111 -> sof_err pulses for one cycle and back[0]=3'b111. After a full frame and a swap, reading address 0 returns 3'b111.
- In IDLE, 4 pixels with wr_sof=0 -> 4 sof_err pulses and no writes; wr_addr stays 0.
- Toggle vsync during FILL -> front_sel unchanged. Assert reset mid-FILL at wr_addr=6000 -> all outputs take their reset values immediately (async).
- With VRAM_CLEAR_EN: wr_ready=0 for 12288 cycles after reset release, then all reads return 0 in both banks.
